alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 77 +++++++
 rtl/alu_mul_iter.sv | 56 +++++
 rtl/alu_mc.sv | 106 ++++++++++
 tb/tb_alu_mc.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: op/state enums, ALUOp and funct encodings, and the instruction decoder for alu_mc
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MUL
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

    localparam logic [1:0] ALUOP_I    = 2'b00;
    localparam logic [1:0] ALUOP_R    = 2'b01;
    localparam logic [1:0] ALUOP_ADDR = 2'b10;
    localparam logic [1:0] ALUOP_BR   = 2'b11;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    typedef struct packed {
        op_e  op;
        logic illegal;
    } dec_t;

    // Unlisted encodings fall back to ADD with the illegal flag raised.
    // I-type funct7 bits are immediate bits, so only the shift-right form inspects them.
    function automatic dec_t decode(input logic [1:0] aluop, input logic [6:0] f7, input logic [2:0] f3);
        dec_t d;
        d.op      = OP_ADD;
        d.illegal = 1'b0;
        case (aluop)
            ALUOP_I: begin
                case (f3)
                    F3_ADD: d.op = OP_ADD;
                    F3_SLL: d.op = OP_SLL;
                    F3_XOR: d.op = OP_XOR;
                    F3_OR:  d.op = OP_OR;
                    F3_AND: d.op = OP_AND;
                    F3_SR: begin
                        if (f7 == F7_ALT)       d.op = OP_SRA;
                        else if (f7 == F7_BASE) d.op = OP_SRL;
                        else                    d.illegal = 1'b1;
                    end
                    default: d.illegal = 1'b1;
                endcase
            end
            ALUOP_R: begin
                case ({f7, f3})
                    {F7_BASE, F3_ADD}: d.op = OP_ADD;
                    {F7_ALT,  F3_ADD}: d.op = OP_SUB;
                    {F7_BASE, F3_SLL}: d.op = OP_SLL;
                    {F7_BASE, F3_SLT}: d.op = OP_SLT;
                    {F7_BASE, F3_XOR}: d.op = OP_XOR;
                    {F7_BASE, F3_SR}:  d.op = OP_SRL;
                    {F7_ALT,  F3_SR}:  d.op = OP_SRA;
                    {F7_BASE, F3_OR}:  d.op = OP_OR;
                    {F7_BASE, F3_AND}: d.op = OP_AND;
                    {F7_MUL,  F3_ADD}: d.op = OP_MUL;
                    default:           d.illegal = 1'b1;
                endcase
            end
            ALUOP_ADDR: d.op = OP_ADD;
            ALUOP_BR:   d.op = OP_SUB;
            default:    d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier retiring MUL_UNROLL multiplier bits per cycle
module alu_mul_iter #(
    parameter int XLEN       = 32,
    parameter int MUL_UNROLL = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int STEPS = XLEN / MUL_UNROLL;
    localparam int CW    = $clog2(STEPS + 1);

    logic            busy;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] acc, ma, mb, part;

    // Sum of the shifted multiplicand copies selected by the low MUL_UNROLL multiplier bits
    always_comb begin
        part = '0;
        for (int j = 0; j < MUL_UNROLL; j++)
            part = part + (mb[j] ? ma << j : '0);
    end

    // done flags the final step so the caller can capture acc+part on the same edge
    assign done    = busy && (cnt == CW'(STEPS - 1));
    assign product = acc + part;

    // Load operands on start, then accumulate and shift until the last step retires
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
            ma   <= '0;
            mb   <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            acc  <= '0;
            ma   <= a;
            mb   <= b;
        end else if (busy) begin
            acc  <= acc + part;
            ma   <= ma << MUL_UNROLL;
            mb   <= mb >> MUL_UNROLL;
            cnt  <= cnt + 1'b1;
            busy <= !done;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: RISC-V style ALU with single-cycle simple ops and an iterative multiplier, valid/ready on both sides
module alu_mc
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_UNROLL = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [9:0]      func_i,
    input  logic [1:0]      ALUOp_i,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    output logic            valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            illegal_o
);

    localparam int SW = $clog2(XLEN);

    state_e          state;
    dec_t            dec;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] alu_res, mul_prod;
    logic            mul_start, mul_done;

    assign dec       = decode(ALUOp_i, func_i[9:3], func_i[2:0]);
    assign shamt     = data2_i[SW-1:0];
    assign ready_o   = (state == S_IDLE);
    assign mul_start = ready_o && valid_i && (dec.op == OP_MUL);

    // Single-cycle result for every op except MUL, computed from the live inputs at acceptance
    always_comb begin
        alu_res = data1_i + data2_i;
        case (dec.op)
            OP_SUB: alu_res = data1_i - data2_i;
            OP_SLL: alu_res = data1_i << shamt;
            OP_SLT: alu_res = {{(XLEN-1){1'b0}}, $signed(data1_i) < $signed(data2_i)};
            OP_XOR: alu_res = data1_i ^ data2_i;
            OP_SRL: alu_res = data1_i >> shamt;
            OP_SRA: alu_res = XLEN'($signed(data1_i) >>> shamt);
            OP_OR:  alu_res = data1_i | data2_i;
            OP_AND: alu_res = data1_i & data2_i;
            default: alu_res = data1_i + data2_i;
        endcase
    end

    alu_mul_iter #(
        .XLEN      (XLEN),
        .MUL_UNROLL(MUL_UNROLL)
    ) u_mul (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start  (mul_start),
        .a      (data1_i),
        .b      (data2_i),
        .done   (mul_done),
        .product(mul_prod)
    );

    // Control FSM: results are captured into output registers and held until the consumer takes them
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= S_IDLE;
            valid_o   <= 1'b0;
            result_o  <= '0;
            zero_o    <= 1'b0;
            illegal_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid_i && dec.op == OP_MUL) begin
                        state <= S_MUL;
                    end else if (valid_i) begin
                        state     <= S_DONE;
                        valid_o   <= 1'b1;
                        result_o  <= alu_res;
                        zero_o    <= (alu_res == '0);
                        illegal_o <= dec.illegal;
                    end
                end
                S_MUL: begin
                    if (mul_done) begin
                        state     <= S_DONE;
                        valid_o   <= 1'b1;
                        result_o  <= mul_prod;
                        zero_o    <= (mul_prod == '0);
                        illegal_o <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        state   <= S_IDLE;
                        valid_o <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: table-driven directed bench for alu_mc plus multi-cycle handshake/reset sequences
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [9:0]  func_i = '0;
    logic [1:0]  ALUOp_i = '0;
    logic [31:0] data1_i = '0, data2_i = '0;
    logic        valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] result_o;
    logic        zero_o, illegal_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_mc #(.XLEN(32), .MUL_UNROLL(1)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .func_i     (func_i),
        .ALUOp_i    (ALUOp_i),
        .data1_i    (data1_i),
        .data2_i    (data2_i),
        .valid_o    (valid_o),
        .out_ready_i(out_ready_i),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .illegal_o  (illegal_o)
    );

    typedef struct {
        logic [1:0]  aluop;
        logic [9:0]  func;
        logic [31:0] d1, d2, res;
        logic        z, il;
        int          lat;
    } vec_t;

    vec_t v[22];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] aluop, input logic [9:0] func, input logic [31:0] d1, input logic [31:0] d2);
        @(negedge clk);
        ALUOp_i = aluop;
        func_i  = func;
        data1_i = d1;
        data2_i = d2;
        valid_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
    endtask

    // lat counts cycles from acceptance: 1 means valid_o is up in the cycle right after it
    task automatic wait_valid(input int pulses, output int lat);
        lat = 1;
        while (!valid_o && lat < 200) begin
            if (lat <= pulses) begin
                @(negedge clk);
                ALUOp_i = 2'b01;
                func_i  = 10'b0000000_000;
                data1_i = 32'd100;
                data2_i = 32'd200;
                valid_i = 1'b1;
                if (lat == 1) chk("busy_ready", ready_o, 0);
            end
            @(posedge clk);
            #1 valid_i = 1'b0;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready_i = 1'b1;
        @(posedge clk);
        #1 out_ready_i = 1'b0;
    endtask

    initial begin
        int lat;
        v[0]  = '{2'b01, 10'b0000000_000, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 1};
        v[1]  = '{2'b11, 10'b0000000_000, 32'h1234,     32'h1234,     32'h0,        1'b1, 1'b0, 1};
        v[2]  = '{2'b01, 10'b0100000_000, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 1'b0, 1};
        v[3]  = '{2'b00, 10'b0100000_101, 32'h80000000, 32'h24,       32'hF8000000, 1'b0, 1'b0, 1};
        v[4]  = '{2'b01, 10'b1111111_111, 32'd3,        32'd4,        32'd7,        1'b0, 1'b1, 1};
        v[5]  = '{2'b00, 10'b0000000_101, 32'h80000000, 32'h24,       32'h08000000, 1'b0, 1'b0, 1};
        v[6]  = '{2'b01, 10'b0000000_010, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0, 1};
        v[7]  = '{2'b01, 10'b0000000_010, 32'h1,        32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 1};
        v[8]  = '{2'b01, 10'b0000000_100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1};
        v[9]  = '{2'b01, 10'b0000000_110, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0, 1};
        v[10] = '{2'b01, 10'b0000000_111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1};
        v[11] = '{2'b01, 10'b0000000_001, 32'h1,        32'h3F,       32'h80000000, 1'b0, 1'b0, 1};
        v[12] = '{2'b01, 10'b0100000_101, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 1'b0, 1};
        v[13] = '{2'b00, 10'b1111111_000, 32'd10,       32'hFFFFFFFF, 32'd9,        1'b0, 1'b0, 1};
        v[14] = '{2'b00, 10'b0000000_100, 32'hFF,       32'h0F,       32'hF0,       1'b0, 1'b0, 1};
        v[15] = '{2'b00, 10'b0000000_010, 32'd2,        32'd3,        32'd5,        1'b0, 1'b1, 1};
        v[16] = '{2'b10, 10'b1111111_111, 32'h1000,     32'h20,       32'h1020,     1'b0, 1'b0, 1};
        v[17] = '{2'b01, 10'b0000001_000, 32'd6,        32'd7,        32'd42,       1'b0, 1'b0, 33};
        v[18] = '{2'b01, 10'b0000001_000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b0, 1'b0, 33};
        v[19] = '{2'b01, 10'b0000001_000, 32'h10000,    32'h10000,    32'h0,        1'b1, 1'b0, 33};
        v[20] = '{2'b00, 10'b0000001_101, 32'd1,        32'd1,        32'd2,        1'b0, 1'b1, 1};
        v[21] = '{2'b01, 10'b0000001_001, 32'd4,        32'd5,        32'd9,        1'b0, 1'b1, 1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_result", result_o, 0);
        chk("rst_zero", zero_o, 0);
        chk("rst_illegal", illegal_o, 0);
        @(negedge clk);
        rst_i = 1'b1;

        for (int i = 0; i < 22; i++) begin
            send(v[i].aluop, v[i].func, v[i].d1, v[i].d2);
            wait_valid(0, lat);
            chk($sformatf("v%0d_result", i), result_o, v[i].res);
            chk($sformatf("v%0d_zero", i), zero_o, v[i].z);
            chk($sformatf("v%0d_illegal", i), illegal_o, v[i].il);
            chk($sformatf("v%0d_latency", i), lat, v[i].lat);
            consume();
        end

        // MUL with valid_i pulses while busy: pulses are dropped, no extra result appears
        send(2'b01, 10'b0000001_000, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_valid(5, lat);
        chk("busy_mul_result", result_o, 32'h1);
        chk("busy_mul_latency", lat, 33);
        consume();
        repeat (3) @(posedge clk);
        #1 chk("busy_no_ghost", valid_o, 0);
        chk("busy_idle_ready", ready_o, 1);

        // Result held in DONE while the consumer stalls, then back-to-back acceptance
        send(2'b01, 10'b0000000_000, 32'd5, 32'd7);
        wait_valid(0, lat);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            data1_i = 32'hDEAD;
            data2_i = 32'hBEEF;
            func_i  = 10'b0100000_000;
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d_valid", k), valid_o, 1);
            chk($sformatf("hold%0d_result", k), result_o, 32'd12);
            chk($sformatf("hold%0d_zero", k), zero_o, 0);
            chk($sformatf("hold%0d_ready", k), ready_o, 0);
        end
        consume();
        chk("hs_ready", ready_o, 1);
        chk("hs_valid", valid_o, 0);
        send(2'b01, 10'b0100000_000, 32'd9, 32'd4);
        wait_valid(0, lat);
        chk("b2b_result", result_o, 32'd5);
        chk("b2b_latency", lat, 1);
        consume();

        // Reset 10 cycles into a MUL discards it; the next MUL runs cleanly
        send(2'b01, 10'b0000001_000, 32'd6, 32'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("midrst_valid", valid_o, 0);
        chk("midrst_ready", ready_o, 1);
        chk("midrst_result", result_o, 0);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        repeat (35) @(posedge clk);
        #1 chk("midrst_no_ghost", valid_o, 0);
        send(2'b01, 10'b0000001_000, 32'd3, 32'd4);
        wait_valid(0, lat);
        chk("postrst_mul_result", result_o, 32'd12);
        chk("postrst_mul_latency", lat, 33);
        chk("postrst_mul_illegal", illegal_o, 0);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
